// File: rtl/multicycle_ctrl.sv
// Main controller for a multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, write strobes and ALU op, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Cond_Chk,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [3:0]       AluControl,
  output logic             illegal_instr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_LINK   = 4'd12, S_LUI    = 4'd13, S_AUIPC  = 4'd14, S_DEAD   = 4'd15
  } state_t;

  state_t state_q, state_d, dec_state;
  logic   dec_illegal, retire;
  logic   pc_w, ir_w, reg_w, mem_w;

  // funct3 -> ALU op; alt_add selects SUB for 000, alt_shift selects SRA for 101
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt_add,
                                        input logic alt_shift);
    case (f3)
      3'b000:  alu_op = alt_add ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0010;
      3'b010:  alu_op = 4'b0011;
      3'b011:  alu_op = 4'b0100;
      3'b100:  alu_op = 4'b0101;
      3'b101:  alu_op = alt_shift ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b1010;
      default: alu_op = 4'b1011;
    endcase
  endfunction

  // opcode dispatch and legality check
  always_comb begin
    dec_state   = S_FETCH;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0100011: dec_state = S_MEMADR;
      7'b0110011:
        if (funct7b5 && funct3 != 3'b000 && funct3 != 3'b101) dec_illegal = 1'b1;
        else dec_state = S_EXR;
      7'b0010011: dec_state = S_EXI;
      7'b1100011:
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
        else dec_state = S_BRANCH;
      7'b1101111: dec_state = S_JAL;
      7'b1100111: dec_state = S_JALR;
      7'b0110111: dec_state = S_LUI;
      7'b0010111: dec_state = S_AUIPC;
      default:    dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_w          = 1'b0;
    ir_w          = 1'b0;
    reg_w         = 1'b0;
    mem_w         = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    AluControl    = 4'b0000;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_w      = mem_ready;
        ir_w      = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b01;
        illegal_instr = dec_illegal;
        state_d       = dec_state;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXR: begin
        ALUSrcA    = 2'b10;
        AluControl = alu_op(funct3, funct7b5, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        AluControl = alu_op(funct3, 1'b0, funct7b5);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        AluControl = {1'b1, funct3};
        pc_w       = Cond_Chk;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = 1'b1;
        state_d   = S_LINK;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // strobes are suppressed while reset is asserted so nothing lands mid-abort
  assign PCWrite  = pc_w  & reset;
  assign IRWrite  = ir_w  & reset;
  assign RegWrite = reg_w & reset;
  assign MemWrite = mem_w & reset;
  assign state    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, Cond_Chk, mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal_instr;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  AluControl, state;
  logic [31:0] retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .Cond_Chk(Cond_Chk), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AluControl(AluControl),
    .illegal_instr(illegal_instr), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [15:0] ctl;   // {pcw,irw,rw,mw,adr,srca,srcb,res,alu,ill}
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   r = 0;

  function automatic exp_t mk(string n, int st, bit pcw, bit irw, bit rw, bit mw, bit adr,
                              bit [1:0] sa, bit [1:0] sb, bit [1:0] rs, bit [3:0] alu,
                              bit ill, int ret);
    exp_t e;
    e.name = n;
    e.st   = 4'(st);
    e.ctl  = {pcw, irw, rw, mw, adr, sa, sb, rs, alu, ill};
    e.ret  = 32'(ret);
    return e;
  endfunction

  function automatic exp_t rst_e();  return mk("reset", 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0); endfunction
  function automatic exp_t f_e(int ret, bit mr);
    return mk("fetch", 0, mr, mr, 0, 0, 0, 0, 2, 2, 0, 0, ret);
  endfunction
  function automatic exp_t d_e(int ret, bit ill);
    return mk("decode", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, ill, ret);
  endfunction
  function automatic exp_t wb_e(int ret); return mk("aluwb", 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ret); endfunction
  function automatic exp_t ma_e(int ret); return mk("memadr", 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, ret); endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic cyc(input logic cc, input logic mr, input exp_t e);
    Cond_Chk  = cc;
    mem_ready = mr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = sb_q.pop_front();
      act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             AluControl, illegal_instr};
      checks++;
      if (state !== e.st || act !== e.ctl || retired !== e.ret) begin
        errors++;
        $display("FAIL %s: got st=%0d ctl=%h ret=%0d, expected st=%0d ctl=%h ret=%0d",
                 e.name, state, act, retired, e.st, e.ctl, e.ret);
      end
    end
  end

  initial begin
    reset = 1'b0; Cond_Chk = 1'b0; mem_ready = 1'b0;
    set_instr(7'b0, 3'b0, 1'b0);
    @(posedge clk); #1;
    cyc(0, 1, rst_e()); cyc(0, 1, rst_e());
    reset = 1'b1;

    set_instr(7'b0110011, 3'b000, 1'b0);  // add
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("exr_add", 6, 0, 0, 0, 0, 0, 2, 0, 0, 4'b0000, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b0110011, 3'b000, 1'b1);  // sub
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("exr_sub", 6, 0, 0, 0, 0, 0, 2, 0, 0, 4'b0001, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b0010011, 3'b101, 1'b1);  // srai
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("exi_srai", 7, 0, 0, 0, 0, 0, 2, 1, 0, 4'b0111, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b0010011, 3'b000, 1'b1);  // addi with bit30 set stays ADD
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("exi_addi", 7, 0, 0, 0, 0, 0, 2, 1, 0, 4'b0000, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b1100011, 3'b000, 1'b0);  // beq taken then not taken
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(1, 1, mk("beq_taken", 9, 1, 0, 0, 0, 0, 2, 0, 0, 4'b1000, 0, r)); r++;
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("beq_not", 9, 0, 0, 0, 0, 0, 2, 0, 0, 4'b1000, 0, r)); r++;

    set_instr(7'b0000011, 3'b010, 1'b0);  // lw with memory stalls
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0)); cyc(0, 1, ma_e(r));
    for (int i = 0; i < 3; i++) cyc(0, 0, mk("memrd_wait", 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, r));
    cyc(0, 1, mk("memrd_done", 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, r));
    cyc(0, 1, mk("memwb", 4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, r)); r++;

    set_instr(7'b0000000, 3'b000, 1'b0);  // illegal opcode, fetch stalls once first
    cyc(0, 0, f_e(r, 0)); cyc(0, 1, f_e(r, 1));
    cyc(0, 1, d_e(r, 1));

    set_instr(7'b1101111, 3'b000, 1'b0);  // jal
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("jal", 10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b1100111, 3'b000, 1'b0);  // jalr
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("jalr", 11, 1, 0, 0, 0, 0, 2, 1, 2, 0, 0, r));
    cyc(0, 1, mk("link", 12, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b0110111, 3'b000, 1'b0);  // lui
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0));
    cyc(0, 1, mk("lui", 13, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, r));
    cyc(0, 1, wb_e(r)); r++;

    set_instr(7'b0100011, 3'b010, 1'b0);  // sw, one stall then complete
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0)); cyc(0, 1, ma_e(r));
    cyc(0, 0, mk("memwr_wait", 5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, r));
    cyc(0, 1, mk("memwr_done", 5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, r)); r++;
    cyc(0, 1, f_e(r, 1)); cyc(0, 1, d_e(r, 0)); cyc(0, 1, ma_e(r));  // sw aborted by reset
    cyc(0, 0, mk("memwr_stall", 5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, r));
    reset = 1'b0; r = 0;
    cyc(0, 0, rst_e()); cyc(0, 1, rst_e());
    reset = 1'b1;
    cyc(0, 1, f_e(r, 1));

    @(negedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
